button_sync_filter: RTL and testbench
=====================================

BUTTON_SYNC_FILTER -- requirements
Module: button_sync_filter

Interface
REQ-001 Parameter STABLE_CYCLES, default 50000, SHALL be the number of consecutive identical synchronized samples needed to accept a level change (1 ms at 50 MHz); legal range >= 1.
REQ-002 Parameter ACTIVE_LOW_IN, default 1, SHALL mean 1 = raw input is pressed-when-low (DE2 KEY), 0 = pressed-when-high.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_hifreq  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 button_raw  input  1  unsynchronized mechanical button pin.
REQ-007 button_clean  output  1  debounced level, 1 = pressed; feeds the downstream pulse-generator stage's button input.
REQ-008 rise  output  1  one-cycle strobe when button_clean goes 0->1.
REQ-009 fall  output  1  one-cycle strobe when button_clean goes 1->0.

Function
REQ-010 button_raw SHALL pass through a 2-flop synchronizer; polarity is normalized after the second flop, so s = 1 means pressed.
REQ-011 The FSM SHALL have four states: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-012 RELEASED: s=1 -> CONFIRM_PRESS with count=1; s=0 -> stay.
REQ-013 CONFIRM_PRESS: s=0 -> RELEASED, count cleared; s=1 with count=STABLE_CYCLES-1 -> PRESSED; otherwise s=1 -> count+1.
REQ-014 PRESSED and CONFIRM_RELEASE SHALL mirror REQ-012/013 with s inverted.
REQ-015 With STABLE_CYCLES=1, the first opposing sample SHALL cause the transition directly from RELEASED/PRESSED; the CONFIRM states are not entered.
REQ-016 The counter width SHALL be ceil(log2(STABLE_CYCLES+1)) bits; it never exceeds STABLE_CYCLES-1 and never wraps.
REQ-017 button_clean SHALL be registered; it is 1 exactly when the state is PRESSED or CONFIRM_RELEASE.
REQ-018 rise SHALL be registered and high for the single cycle in which button_clean first reads 1; fall does the same for the first cycle of 0.
REQ-019 rise and fall SHALL never be high in the same cycle; back-to-back strobes are separated by at least STABLE_CYCLES cycles.
REQ-020 Latency: after a raw change that stays stable from before edge 0, button_clean SHALL change after edge STABLE_CYCLES+1 (2 sync edges, then STABLE_CYCLES samples at edges 2..STABLE_CYCLES+1).
REQ-021 Glitches shorter than STABLE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-022 A bounce during a CONFIRM state SHALL restart qualification from the stable state with no partial credit.

Reset
REQ-023 On rst_n=0 the FSM SHALL go asynchronously to RELEASED with count=0.
REQ-024 On rst_n=0, button_clean, rise and fall SHALL be 0.
REQ-025 On rst_n=0, both synchronizer flops SHALL load the released raw level: 1 if ACTIVE_LOW_IN=1, else 0.
REQ-026 Reset asserted mid-qualification or while PRESSED SHALL abandon the state without emitting fall.
REQ-027 After release of rst_n, a button still held SHALL requalify fully and emit exactly one rise.
REQ-028 Reset release SHALL be synchronous to clk_hifreq at the integration level.

Verification (STABLE_CYCLES=4, ACTIVE_LOW_IN=1)
REQ-029 Press: button_raw 1->0 before edge 0, held -> button_clean=1 and rise=1 after edge 5; rise=0 after edge 6.
REQ-030 Bounce: raw low for 2 cycles, high for 1, then low steady -> single rise, 4 stable samples after the last bounce; no earlier activity.
REQ-031 Glitch: raw low for 3 cycles, then back high -> button_clean, rise and fall all stay 0.
REQ-032 Release: from pressed, raw 0->1 held -> fall=1 for one cycle and button_clean=0 after edge 5 relative to the change.
REQ-033 Reset mid-press: rst_n low during PRESSED, raw held low -> outputs 0 immediately with no fall; after rst_n high, rise follows 6 edges later.
REQ-034 STABLE_CYCLES=1 build: a raw pulse lasting 2 cycles -> one rise then one fall, each a single cycle wide.

Source files
------------

// File: rtl/button_sync_filter.sv
// Debounces a mechanical button: 2-flop sync, polarity normalize, 4-state qualify FSM.
// button_clean/rise/fall all update on the edge that accepts a change (STABLE_CYCLES+2 edges after a raw change).
module button_sync_filter #(
   parameter int STABLE_CYCLES = 50000,
   parameter bit ACTIVE_LOW_IN = 1'b1
) (
   input  logic clk_hifreq,
   input  logic rst_n,
   input  logic button_raw,
   output logic button_clean,
   output logic rise,
   output logic fall
);

   localparam int              CW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]   ONE  = CW'(1);
   localparam logic            REL  = ACTIVE_LOW_IN;

   typedef enum logic [1:0] {
      RELEASED,
      CONFIRM_PRESS,
      PRESSED,
      CONFIRM_RELEASE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic          r_sync1;
   logic          r_sync2;
   logic          r_clean;
   logic          r_rise;
   logic          r_fall;
   logic          w_s;

   // Synchronizer resets to the released pin level so reset never looks like a press.
   always_ff @(posedge clk_hifreq or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= REL;
         r_sync2 <= REL;
      end else begin
         r_sync1 <= button_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2 ^ REL;

   always_ff @(posedge clk_hifreq or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RELEASED;
         r_count <= '0;
         r_clean <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            RELEASED: begin
               if (w_s) begin
                  if (STABLE_CYCLES == 1) begin
                     r_state <= PRESSED;
                     r_clean <= 1'b1;
                     r_rise  <= 1'b1;
                     r_count <= '0;
                  end else begin
                     r_state <= CONFIRM_PRESS;
                     r_count <= ONE;
                  end
               end
            end
            CONFIRM_PRESS: begin
               if (!w_s) begin
                  r_state <= RELEASED;
                  r_count <= '0;
               end else if (r_count == LAST) begin
                  r_state <= PRESSED;
                  r_clean <= 1'b1;
                  r_rise  <= 1'b1;
                  r_count <= '0;
               end else begin
                  r_count <= r_count + ONE;
               end
            end
            PRESSED: begin
               if (!w_s) begin
                  if (STABLE_CYCLES == 1) begin
                     r_state <= RELEASED;
                     r_clean <= 1'b0;
                     r_fall  <= 1'b1;
                     r_count <= '0;
                  end else begin
                     r_state <= CONFIRM_RELEASE;
                     r_count <= ONE;
                  end
               end
            end
            CONFIRM_RELEASE: begin
               if (w_s) begin
                  r_state <= PRESSED;
                  r_count <= '0;
               end else if (r_count == LAST) begin
                  r_state <= RELEASED;
                  r_clean <= 1'b0;
                  r_fall  <= 1'b1;
                  r_count <= '0;
               end else begin
                  r_count <= r_count + ONE;
               end
            end
            default: begin
               r_state <= RELEASED;
               r_count <= '0;
               r_clean <= 1'b0;
            end
         endcase
      end
   end

   assign button_clean = r_clean;
   assign rise         = r_rise;
   assign fall         = r_fall;

endmodule

// File: tb/tb_button_sync_filter.sv
// Scoreboard bench: stimulus queues expected strobes (kind + sample cycle), monitors pop on every strobe.
module tb_button_sync_filter;

   typedef struct {
      bit is_rise;
      int at;
   } ev_t;

   logic clk_hifreq = 1'b0;
   logic rst_n      = 1'b0;
   logic raw4       = 1'b1;
   logic raw1       = 1'b1;
   logic clean4, rise4, fall4;
   logic clean1, rise1, fall1;

   int   edge_cnt = 0;
   int   checks   = 0;
   int   errors   = 0;
   ev_t  q4[$];
   ev_t  q1[$];

   button_sync_filter #(.STABLE_CYCLES(4), .ACTIVE_LOW_IN(1'b1)) dut4 (
      .clk_hifreq  (clk_hifreq),
      .rst_n       (rst_n),
      .button_raw  (raw4),
      .button_clean(clean4),
      .rise        (rise4),
      .fall        (fall4)
   );

   button_sync_filter #(.STABLE_CYCLES(1), .ACTIVE_LOW_IN(1'b1)) dut1 (
      .clk_hifreq  (clk_hifreq),
      .rst_n       (rst_n),
      .button_raw  (raw1),
      .button_clean(clean1),
      .rise        (rise1),
      .fall        (fall1)
   );

   always #5 clk_hifreq = ~clk_hifreq;
   always @(posedge clk_hifreq) edge_cnt <= edge_cnt + 1;

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk_hifreq);
      #1;
   endtask

   // Monitors: every strobe must match the head of its queue in kind, cycle and level.
   always @(negedge clk_hifreq) begin
      ev_t e;
      if (rise4 || fall4) begin
         check_eq("dut4_rise_and_fall_exclusive", int'(rise4 & fall4), 0);
         if (q4.size() == 0) begin
            check_eq("dut4_unexpected_strobe", int'(rise4), 0);
            check_eq("dut4_unexpected_strobe_fall", int'(fall4), 0);
         end else begin
            e = q4.pop_front();
            check_eq("dut4_strobe_kind_rise", int'(rise4), int'(e.is_rise));
            check_eq("dut4_strobe_cycle", edge_cnt, e.at);
            check_eq("dut4_clean_at_strobe", int'(clean4), int'(e.is_rise));
         end
      end
      if (rise1 || fall1) begin
         check_eq("dut1_rise_and_fall_exclusive", int'(rise1 & fall1), 0);
         if (q1.size() == 0) begin
            check_eq("dut1_unexpected_strobe", int'(rise1), 0);
            check_eq("dut1_unexpected_strobe_fall", int'(fall1), 0);
         end else begin
            e = q1.pop_front();
            check_eq("dut1_strobe_kind_rise", int'(rise1), int'(e.is_rise));
            check_eq("dut1_strobe_cycle", edge_cnt, e.at);
            check_eq("dut1_clean_at_strobe", int'(clean1), int'(e.is_rise));
         end
      end
   end

   initial begin
      int n;
      #2;
      check_eq("reset_clean4", int'(clean4), 0);
      check_eq("reset_rise4",  int'(rise4),  0);
      check_eq("reset_fall4",  int'(fall4),  0);
      check_eq("reset_clean1", int'(clean1), 0);
      check_eq("reset_rise1",  int'(rise1),  0);
      check_eq("reset_fall1",  int'(fall1),  0);
      wait_edges(3);
      rst_n = 1'b1;
      wait_edges(3);

      // Clean press then release: strobes after relative edge 5.
      n = edge_cnt; raw4 = 1'b0; q4.push_back('{1'b1, n + 6});
      wait_edges(10);
      check_eq("press_clean_held", int'(clean4), 1);
      n = edge_cnt; raw4 = 1'b1; q4.push_back('{1'b0, n + 6});
      wait_edges(10);
      check_eq("release_clean_held", int'(clean4), 0);

      // 3-cycle glitch: never qualifies.
      raw4 = 1'b0;
      wait_edges(3);
      raw4 = 1'b1;
      wait_edges(10);
      check_eq("glitch_clean", int'(clean4), 0);

      // Bounce low2/high1/low: qualification restarts from the last change.
      raw4 = 1'b0;
      wait_edges(2);
      raw4 = 1'b1;
      wait_edges(1);
      n = edge_cnt; raw4 = 1'b0; q4.push_back('{1'b1, n + 6});
      wait_edges(10);
      n = edge_cnt; raw4 = 1'b1; q4.push_back('{1'b0, n + 6});
      wait_edges(10);

      // Reset while pressed: no fall, then a single requalified rise.
      n = edge_cnt; raw4 = 1'b0; q4.push_back('{1'b1, n + 6});
      wait_edges(10);
      rst_n = 1'b0;
      #1;
      check_eq("midreset_clean", int'(clean4), 0);
      check_eq("midreset_rise",  int'(rise4),  0);
      check_eq("midreset_fall",  int'(fall4),  0);
      wait_edges(3);
      n = edge_cnt; rst_n = 1'b1; q4.push_back('{1'b1, n + 6});
      wait_edges(10);
      check_eq("after_reset_clean", int'(clean4), 1);
      n = edge_cnt; raw4 = 1'b1; q4.push_back('{1'b0, n + 6});
      wait_edges(10);

      // STABLE_CYCLES=1: a 2-cycle low pulse gives one rise and one fall.
      n = edge_cnt; raw1 = 1'b0;
      q1.push_back('{1'b1, n + 3});
      q1.push_back('{1'b0, n + 5});
      wait_edges(2);
      raw1 = 1'b1;
      wait_edges(10);

      check_eq("dut4_pending_events", q4.size(), 0);
      check_eq("dut1_pending_events", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
